// File: rtl/systolic_tile_engine.sv
// N x N signed matrix-multiply tile with multi-tile accumulation.
// Row-streamed operand load, requantised back-pressured row drain.
module systolic_tile_engine #(
   parameter int ARRAY_SIZE = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int ROW_W      = ($clog2(ARRAY_SIZE) > 1) ? $clog2(ARRAY_SIZE) : 1,
   parameter int SH_W       = $clog2(ACC_WIDTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sel,
   input  logic [ROW_W-1:0]                 in_row,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
   input  logic                             start,
   input  logic                             acc_mode,
   input  logic [SH_W-1:0]                  shift_amt,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ROW_W-1:0]                 out_row,
   output logic [ARRAY_SIZE*OUT_WIDTH-1:0]  out_data,
   output logic                             out_last,
   output logic                             done,
   output logic                             sat_flag
);

   localparam int N     = ARRAY_SIZE;
   localparam int DW    = DATA_WIDTH;
   localparam int AW    = ACC_WIDTH;
   localparam int OW    = OUT_WIDTH;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int CNT_W = $clog2(3 * N);

   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(3 * N - 2);
   localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
   localparam logic [ROW_W:0]   ROW_N    = (ROW_W + 1)'(N);

   localparam logic signed [AW-1:0] OMAX =
      {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic signed [AW-1:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ROW_W-1:0]        row_q;
   logic [SH_W-1:0]         shift_q;
   logic                    sat_q;
   logic                    done_q;

   logic signed [DW-1:0]    a_q   [N][N];
   logic signed [DW-1:0]    b_q   [N][N];
   logic signed [AW-1:0]    acc_q [N][N];
   logic signed [AW-1:0]    acc_d [N][N];

   logic signed [PW-1:0]    prod;
   logic [ROW_W-1:0]        k_idx;
   logic signed [AW-1:0]    shv;
   logic [N*OW-1:0]         row_data;
   logic                    row_sat;

   // One rank-1 update (column k of A times row k of B) per early COMPUTE cycle
   always_comb begin
      acc_d = acc_q;
      prod  = '0;
      k_idx = cnt_q[ROW_W-1:0];
      if (state_q == COMPUTE && cnt_q < CNT_N) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               prod = PW'(a_q[i][k_idx]) * PW'(b_q[k_idx][j]);
               acc_d[i][j] = acc_q[i][j] + {{(AW - PW){prod[PW-1]}}, prod};
            end
         end
      end
   end

   // Requantise the presented row: arithmetic shift then clamp
   always_comb begin
      row_data = '0;
      row_sat  = 1'b0;
      shv      = '0;
      for (int j = 0; j < N; j++) begin
         shv = acc_q[row_q][j] >>> shift_q;
         if (shv > OMAX) begin
            row_data[j*OW +: OW] = OMAX[OW-1:0];
            row_sat = 1'b1;
         end else if (shv < OMIN) begin
            row_data[j*OW +: OW] = OMIN[OW-1:0];
            row_sat = 1'b1;
         end else begin
            row_data[j*OW +: OW] = shv[OW-1:0];
         end
      end
   end

   assign in_ready  = (state_q == IDLE) && !start;
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DRAIN);
   assign out_row   = row_q;
   assign out_last  = out_valid && (row_q == ROW_LAST);
   assign out_data  = out_valid ? row_data : '0;
   assign done      = done_q;
   assign sat_flag  = sat_q;

   // Tile FSM with operand storage and accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         shift_q <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_q[i][j]   <= '0;
               b_q[i][j]   <= '0;
               acc_q[i][j] <= '0;
            end
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  shift_q <= shift_amt;
                  sat_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= COMPUTE;
                  if (!acc_mode) begin
                     for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                           acc_q[i][j] <= '0;
                        end
                     end
                  end
               end else if (in_valid && ({1'b0, in_row} < ROW_N)) begin
                  for (int j = 0; j < N; j++) begin
                     if (in_sel) b_q[in_row][j] <= in_data[j*DW +: DW];
                     else        a_q[in_row][j] <= in_data[j*DW +: DW];
                  end
               end
            end
            COMPUTE: begin
               acc_q <= acc_d;
               if (cnt_q == CNT_END) begin
                  state_q <= DRAIN;
                  row_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row_sat) sat_q <= 1'b1;
                  if (row_q == ROW_LAST) begin
                     state_q <= IDLE;
                     row_q   <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     row_q <= row_q + ROW_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Scoreboard bench for systolic_tile_engine (N=4, 8-bit in, 16-bit out).
// Directed vectors; a negedge monitor pops expected rows on each handshake.
module tb_systolic_tile_engine;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int OW = 16;
   localparam int RW = 2;
   localparam int SW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_sel = 1'b0;
   logic [RW-1:0]   in_row = '0;
   logic [N*DW-1:0] in_data = '0;
   logic            start = 1'b0;
   logic            acc_mode = 1'b0;
   logic [SW-1:0]   shift_amt = '0;
   logic            busy;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [RW-1:0]   out_row;
   logic [N*OW-1:0] out_data;
   logic            out_last;
   logic            done;
   logic            sat_flag;

   always #5 clk = ~clk;

   systolic_tile_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_row    (in_row),
      .in_data   (in_data),
      .start     (start),
      .acc_mode  (acc_mode),
      .shift_amt (shift_amt),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done),
      .sat_flag  (sat_flag)
   );

   typedef struct {
      logic [RW-1:0]   row;
      logic [N*OW-1:0] data;
      logic            last;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0 = 0;
   int fv_cyc = -100;
   int done_cyc = -100;
   int done_cnt = 0;
   int dc0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pk8(input int a, input int b,
                                       input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [63:0] pk16(input int a, input int b,
                                        input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic push(input int r, input logic [63:0] d);
      exp_t e;
      e.row  = RW'(r);
      e.data = d;
      e.last = (r == N - 1);
      sb.push_back(e);
   endtask

   task automatic push_b(input int k);
      for (int r = 0; r < N; r++)
         push(r, pk16(k * (4 * r + 1), k * (4 * r + 2),
                      k * (4 * r + 3), k * (4 * r + 4)));
   endtask

   task automatic push_all(input int v);
      for (int r = 0; r < N; r++) push(r, pk16(v, v, v, v));
   endtask

   // Monitor: scoreboard pops, stall stability, done placement
   logic            pv = 1'b0;
   logic            pr = 1'b0;
   logic            phl = 1'b0;
   logic [RW-1:0]   prow = '0;
   logic [N*OW-1:0] pdat = '0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         pv  = 1'b0;
         pr  = 1'b0;
         phl = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_row", out_row, prow);
            chk("stall_data", out_data, pdat);
         end
         if (phl) chk("done_pulse", done, 1'b1);
         if (done) begin
            chk("done_after_last", phl, 1'b1);
            done_cyc = cyc;
            done_cnt++;
         end
         if (out_valid && !pv) fv_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_row: got row %0d want none", out_row);
            end else begin
               e = sb.pop_front();
               chk("row_idx", out_row, e.row);
               chk("row_data", out_data, e.data);
               chk("row_last", out_last, e.last);
            end
         end
         pv   = out_valid;
         pr   = out_ready;
         prow = out_row;
         pdat = out_data;
         phl  = out_valid && out_ready && out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic s, input int r, input logic [31:0] d);
      in_valid = 1'b1;
      in_sel   = s;
      in_row   = RW'(r);
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load1();
      for (int r = 0; r < N; r++) begin
         wr(1'b0, r, pk8(r == 0, r == 1, r == 2, r == 3));
         wr(1'b1, r, pk8(4 * r + 1, 4 * r + 2, 4 * r + 3, 4 * r + 4));
      end
   endtask

   task automatic load_const(input int av, input int bv);
      for (int r = 0; r < N; r++) begin
         wr(1'b0, r, pk8(av, av, av, av));
         wr(1'b1, r, pk8(bv, bv, bv, bv));
      end
   endtask

   task automatic start_tile(input logic m, input int sh);
      dc0       = done_cnt;
      start     = 1'b1;
      acc_mode  = m;
      shift_amt = SW'(sh);
      tick();
      t0       = cyc;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == dc0 && n < 200) begin
         tick();
         n++;
      end
      if (done_cnt == dc0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got none want done within 200");
      end
   endtask

   task automatic run(input logic m, input int sh);
      start_tile(m, sh);
      wait_done();
   endtask

   task automatic chk_timing(input string nm);
      chk({nm, "_first_valid"}, 128'(fv_cyc - t0), 128'(3 * N - 1));
      chk({nm, "_done_time"}, 128'(done_cyc - t0), 128'(4 * N - 1));
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_in_ready"}, in_ready, 1'b1);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_out_valid"}, out_valid, 1'b0);
      chk({nm, "_out_row"}, out_row, '0);
      chk({nm, "_out_data"}, out_data, '0);
      chk({nm, "_out_last"}, out_last, 1'b0);
      chk({nm, "_done"}, done, 1'b0);
      chk({nm, "_sat"}, sat_flag, 1'b0);
   endtask

   initial begin
      int n;
      logic [6:0] pat;

      repeat (2) tick();
      chk_reset_outs("rst");
      rst_n = 1'b1;
      tick();

      // 1: identity x B
      load1();
      push_b(1);
      run(1'b0, 0);
      chk_timing("t1");
      chk("t1_sat", sat_flag, 1'b0);

      // 2: accumulate then clear
      push_b(2);
      run(1'b1, 0);
      chk_timing("t2");
      push_b(1);
      run(1'b0, 0);

      // 3: saturation and shift
      load_const(127, 127);
      push_all(32767);
      run(1'b0, 0);
      chk("t3_sat_hi", sat_flag, 1'b1);
      push_all(16129);
      run(1'b0, 2);
      chk("t3_sat_shift", sat_flag, 1'b0);
      load_const(-128, 127);
      push_all(-32768);
      run(1'b0, 0);
      chk("t3_sat_lo", sat_flag, 1'b1);

      // 4: back-pressure pattern 1,0,0,1,0,1,1
      load1();
      out_ready = 1'b0;
      push_b(1);
      start_tile(1'b0, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("t4_valid_seen", out_valid, 1'b1);
      pat = 7'b1101001;
      for (int i = 0; i < 7; i++) begin
         out_ready = pat[i];
         tick();
      end
      out_ready = 1'b1;
      wait_done();
      chk("t4_sat", sat_flag, 1'b0);

      // 5: disturbances while busy
      push_b(1);
      start_tile(1'b0, 0);
      repeat (3) tick();
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_row   = '0;
      in_data  = pk8(9, 9, 9, 9);
      start    = 1'b1;
      #1;
      chk("t5_ready_compute", in_ready, 1'b0);
      chk("t5_busy", busy, 1'b1);
      tick();
      in_sel  = 1'b1;
      start   = 1'b0;
      in_data = pk8(7, 7, 7, 7);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      start = 1'b1;
      #1;
      chk("t5_ready_drain", in_ready, 1'b0);
      tick();
      start = 1'b0;
      wait_done();
      chk_timing("t5");

      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_row   = '0;
      in_data  = pk8(5, 5, 5, 5);
      push_b(1);
      start_tile(1'b0, 0);
      wait_done();

      // 6: reset mid-compute clears accumulators
      start_tile(1'b1, 0);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk_reset_outs("t6");
      tick();
      rst_n = 1'b1;
      tick();
      load1();
      push_b(1);
      run(1'b1, 0);

      repeat (3) tick();
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_tile_engine.md
Name: systolic_tile_engine

Overview:
Parametrised N x N signed-integer matrix-multiply tile engine. It computes C = A*B, or accumulates C += A*B across K-tiles. Operands load over a valid/ready row stream. Results are requantised (arithmetic shift plus saturation) and drained row by row over a valid/ready output stream. The block is the next-generation compute tile of the accelerator and replaces fixed-size, fixed-read result access with streamed, back-pressured output and multi-tile accumulation.

Parameters:
ARRAY_SIZE, 4, N: tile dimension (rows and columns); legal range 2..16
DATA_WIDTH, 8, signed operand width
ACC_WIDTH, 32, signed accumulator width; must be >= 2*DATA_WIDTH + clog2(N)
OUT_WIDTH, 16, signed requantised output element width; must be <= ACC_WIDTH
ROW_W, max(1,$clog2(ARRAY_SIZE)), derived: row index width
SH_W, $clog2(ACC_WIDTH), derived: shift amount width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand row valid
in_ready  out  1  operand row accepted when in_valid && in_ready
in_sel  in  1  0 = write matrix A row, 1 = write matrix B row
in_row  in  ROW_W  target row index
in_data  in  N*DATA_WIDTH  packed row; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
start  in  1  begin tile (sampled only in IDLE)
acc_mode  in  1  sampled with start: 0 = clear accumulators, 1 = accumulate onto previous C
shift_amt  in  SH_W  sampled with start: arithmetic right shift for requantisation
busy  out  1  high in COMPUTE and DRAIN
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts row
out_row  out  ROW_W  index of presented row
out_data  out  N*OUT_WIDTH  packed requantised row, element j at [j*OUT_WIDTH +: OUT_WIDTH]
out_last  out  1  high with out_valid on row N-1
done  out  1  one-cycle pulse after the last row handshake
sat_flag  out  1  sticky per tile: any element saturated; cleared when a start is accepted

Behaviour:
- Reset: state = IDLE; A, B and accumulators cleared to 0. Outputs: in_ready=1, busy=0, out_valid=0, out_row=0, out_data=0, out_last=0, done=0, sat_flag=0.
- States: IDLE -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - in_ready = !start.
  - An accepted write stores in_data into row in_row of A or B on the clock edge.
  - If in_row >= N, the write is accepted and discarded.
  - start=1 latches acc_mode and shift_amt, clears sat_flag, and moves to COMPUTE. If acc_mode=0, the accumulators are zeroed at entry.
- COMPUTE:
  - Exactly 3N-1 cycles, counter 0..3N-2, in_ready=0.
  - At exit every accumulator C[i][j] equals its prior value (or 0) + sum_k A[i][k]*B[k][j].
  - Internal structure is free: skewed systolic array or otherwise. Cycle count and result are fixed.
- DRAIN:
  - out_valid=1; rows are presented 0..N-1 in order.
  - Row advances only on out_valid && out_ready.
  - out_data, out_row and out_last are stable while stalled.
  - After the row N-1 handshake: out_valid drops, done=1 for one cycle, state = IDLE.
  - Accumulators retain values for a subsequent acc_mode=1 tile.
- Timing: start sampled at edge t -> busy=1 from t+1, first out_valid at t+3N. With out_ready held high, done is high in cycle t+4N.
- Arithmetic:
  - Products are DATA_WIDTH x DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - Output element = saturate_OUT_WIDTH(acc >>> shift_amt), clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - A clamp sets sat_flag when that row is handshaken.
- start while busy: ignored, no effect. in_valid during COMPUTE/DRAIN: not accepted, storage unchanged.
- Asynchronous reset mid-COMPUTE or mid-DRAIN: immediate return to reset state; accumulators are cleared.

Test Plan:
1. N=4, A=identity, B rows {1..4},{5..8},{9..12},{13..16}, acc_mode=0, shift=0, out_ready=1, start at t -> out_valid first at t+12; rows equal B; out_last on row 3; done at t+16; sat_flag=0.
2. Repeat test 1 with start acc_mode=1 -> rows are 2*B ({2,4,6,8}...); then a start with acc_mode=0 -> rows are B again.
3. A all 127, B all 127, shift=0 -> every element 64516 saturates to 32767, sat_flag=1. Shift=2 -> 16129, sat_flag=0. A all -128, B all 127, shift=0 -> -32768, sat_flag=1.
4. out_ready pattern 1,0,0,1,0,1,1 -> out_data/out_row stable across stalls, rows strictly 0..3, done only in the cycle after the row-3 handshake.
5. start pulsed during COMPUTE and DRAIN, in_valid writes during COMPUTE -> no restart, in_ready=0, results are those of the original operands. Start and in_valid in the same IDLE cycle -> write not accepted.
6. Assert rst_n=0 at COMPUTE cycle 5 -> all outputs at reset values. Reload test 1 operands and start with acc_mode=1 -> rows equal B, not 2*B.
